deserializer: RTL and testbench

//   Receive-side counterpart of the serializer. Collects an MSB-first serial bit stream

---
 rtl/deserializer_pkg.sv | 22 ++
 rtl/deserializer_if.sv | 31 +++
 rtl/deser_gap_timer.sv | 30 +++
 rtl/deserializer.sv | 126 ++++++++++++
 tb/tb_deserializer.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/deserializer_pkg.sv
// Shared types and defaults for the serial-to-parallel receiver.
//   state_t        : receiver FSM states
//   DEF_*          : default parameter values
//   mod_from_count : maps a bit count onto the data_mod encoding (0 = full word)
package deserializer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    FLUSH
  } state_t;

  localparam int unsigned DEF_DATA_BUS_WIDTH = 16;
  localparam int unsigned DEF_DATA_MOD_WIDTH = $clog2(DEF_DATA_BUS_WIDTH);
  localparam int unsigned DEF_GAP_CYCLES     = 1;

  function automatic int unsigned mod_from_count(input int unsigned count,
                                                 input int unsigned bus_width);
    return count % bus_width;
  endfunction

endpackage

// File: rtl/deserializer_if.sv
// Bundle of the serial input stream and the parallel output word.
//   ser_data / ser_data_val : MSB-first serial bit and its valid strobe
//   data / data_mod         : parallel word and valid bit count (0 = full word)
//   data_val                : one-cycle word strobe
//   busy                    : partial word in progress
// master drives the serial stream and observes the word; slave is the receiver.
interface deserializer_if
  import deserializer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH)
);

  logic                      ser_data;
  logic                      ser_data_val;
  logic [DATA_BUS_WIDTH-1:0] data;
  logic [DATA_MOD_WIDTH-1:0] data_mod;
  logic                      data_val;
  logic                      busy;

  modport master (
    output ser_data, ser_data_val,
    input  data, data_mod, data_val, busy
  );

  modport slave (
    input  ser_data, ser_data_val,
    output data, data_mod, data_val, busy
  );

endinterface

// File: rtl/deser_gap_timer.sv
// Counts consecutive idle cycles of the serial stream.
//   clk_i, srst_i : clock, synchronous active-high reset
//   run           : an idle cycle that counts towards the gap (held low otherwise)
//   expire        : high in the cycle whose idle makes the gap reach GAP_CYCLES
module deser_gap_timer #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic clk_i,
  input  logic srst_i,
  input  logic run,
  output logic expire
);

  localparam int unsigned CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  logic [CW-1:0] cnt_q;

  // Combinational on the current idle cycle so the partial word can be
  // emitted on the very next cycle.
  assign expire = run && (cnt_q == CW'(GAP_CYCLES - 1));

  always_ff @(posedge clk_i) begin
    if (srst_i || !run || expire) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

endmodule

// File: rtl/deserializer.sv
// Serial-to-parallel receiver. Packs an MSB-first bit stream into words of
// DATA_BUS_WIDTH bits; emits on a full word, or emits a partial word once the
// stream has been idle for GAP_CYCLES cycles.
//   clk_i   : clock, all logic on posedge
//   srst_i  : synchronous active-high reset
//   bus     : deserializer_if slave (serial input, parallel word output)
module deserializer
  import deserializer_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = DEF_DATA_BUS_WIDTH,
  parameter int unsigned DATA_MOD_WIDTH = $clog2(DATA_BUS_WIDTH),
  parameter int unsigned GAP_CYCLES     = DEF_GAP_CYCLES
) (
  input logic           clk_i,
  input logic           srst_i,
  deserializer_if.slave bus
);

  state_t                    state_q, state_d;
  logic [DATA_MOD_WIDTH-1:0] count_q, count_d;
  logic [DATA_BUS_WIDTH-1:0] word_q,  word_d;
  logic [DATA_BUS_WIDTH-1:0] word_ins;
  logic [DATA_MOD_WIDTH-1:0] wr_idx;
  logic                      last_bit;

  logic [DATA_BUS_WIDTH-1:0] data_q, data_d;
  logic [DATA_MOD_WIDTH-1:0] mod_q,  mod_d;
  logic                      val_q,  val_d;
  logic                      busy_q, busy_d;

  logic gap_run;
  logic gap_expire;

  assign gap_run = (state_q == COLLECT) && !bus.ser_data_val;

  deser_gap_timer #(
    .GAP_CYCLES(GAP_CYCLES)
  ) u_gap (
    .clk_i  (clk_i),
    .srst_i (srst_i),
    .run    (gap_run),
    .expire (gap_expire)
  );

  // Width is a power of two, so W-1-count is the bitwise complement of count.
  assign wr_idx   = ~count_q;
  assign last_bit = (count_q == '1);

  always_comb begin
    word_ins         = word_q;
    word_ins[wr_idx] = bus.ser_data;
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    data_d  = data_q;
    mod_d   = mod_q;
    val_d   = 1'b0;

    if (bus.ser_data_val) begin
      // Shift/count registers are clear outside COLLECT, so a bit arriving in
      // IDLE or in the flush cycle starts a new word without a bubble.
      state_d = COLLECT;
      if (last_bit) begin
        data_d  = word_ins;
        mod_d   = '0;
        val_d   = 1'b1;
        word_d  = '0;
        count_d = '0;
      end else begin
        word_d  = word_ins;
        count_d = count_q + DATA_MOD_WIDTH'(1);
      end
    end else begin
      case (state_q)
        COLLECT: begin
          if (gap_expire) begin
            if (count_q != '0) begin
              // Load the partial word now; FLUSH is the cycle it is presented.
              data_d  = word_q;
              mod_d   = DATA_MOD_WIDTH'(mod_from_count(32'(count_q), DATA_BUS_WIDTH));
              val_d   = 1'b1;
              word_d  = '0;
              count_d = '0;
              state_d = FLUSH;
            end else begin
              state_d = IDLE;
            end
          end
        end
        FLUSH:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    busy_d = (count_d != '0);
  end

  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      word_q  <= '0;
      data_q  <= '0;
      mod_q   <= '0;
      val_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
      data_q  <= data_d;
      mod_q   <= mod_d;
      val_q   <= val_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.data     = data_q;
  assign bus.data_mod = mod_q;
  assign bus.data_val = val_q;
  assign bus.busy     = busy_q;

endmodule

// File: tb/tb_deserializer.sv
// Self-checking bench for deserializer: one instance with GAP_CYCLES=1, one
// with GAP_CYCLES=3. Expected words are queued as stimulus is driven and
// compared (data, mod, arrival cycle) when data_val is seen.
module tb_deserializer;
  import deserializer_pkg::*;

  localparam int unsigned W = DEF_DATA_BUS_WIDTH;
  localparam int unsigned M = $clog2(W);

  logic clk  = 1'b0;
  logic srst = 1'b1;
  always #5 clk = ~clk;

  deserializer_if #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) bus1 ();
  deserializer_if #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M)) bus3 ();

  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M), .GAP_CYCLES(1)) dut1 (
    .clk_i (clk), .srst_i (srst), .bus (bus1)
  );
  deserializer #(.DATA_BUS_WIDTH(W), .DATA_MOD_WIDTH(M), .GAP_CYCLES(3)) dut3 (
    .clk_i (clk), .srst_i (srst), .bus (bus3)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] data;
    logic [M-1:0] mod;
    int unsigned  cyc;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];

  typedef struct {
    logic [W-1:0] word;
    int unsigned  nbits;
    int unsigned  gap;
    logic [W-1:0] exp_data;
    logic [M-1:0] exp_mod;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic score(input int sel, input logic [W-1:0] d, input logic [M-1:0] m);
    exp_t e;
    if ((sel == 1 && q1.size() == 0) || (sel == 3 && q3.size() == 0)) begin
      checks++;
      errors++;
      $display("FAIL gap%0d unexpected word: got data %0h mod %0d at cycle %0d expected none",
               sel, d, m, cyc);
    end else begin
      e = (sel == 1) ? q1.pop_front() : q3.pop_front();
      check($sformatf("gap%0d data", sel), 32'(d), 32'(e.data));
      check($sformatf("gap%0d mod", sel), 32'(m), 32'(e.mod));
      check($sformatf("gap%0d emit cycle", sel), cyc, e.cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!srst) begin
      if (bus1.data_val !== 1'b0) score(1, bus1.data, bus1.data_mod);
      if (bus3.data_val !== 1'b0) score(3, bus3.data, bus3.data_mod);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present one serial cycle; returns #1 after the edge that samples it.
  task automatic drive(input int sel, input logic v, input logic d);
    if (sel == 1) begin
      bus1.ser_data_val = v;
      bus1.ser_data     = d;
    end else begin
      bus3.ser_data_val = v;
      bus3.ser_data     = d;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int sel, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) drive(sel, 1'b0, 1'($urandom));
  endtask

  // Send the top nbits of word, queue the expected result, then idle gap cycles.
  task automatic send(input int sel, input logic [W-1:0] word, input int unsigned nbits,
                      input int unsigned gap, input int unsigned g,
                      input logic [W-1:0] exp_data, input logic [M-1:0] exp_mod);
    exp_t e;
    for (int unsigned i = 0; i < nbits; i++) drive(sel, 1'b1, word[W-1-i]);
    e.data = exp_data;
    e.mod  = exp_mod;
    e.cyc  = (nbits == W) ? cyc : cyc + g;
    if (sel == 1) q1.push_back(e);
    else          q3.push_back(e);
    idle(sel, gap);
  endtask

  vec_t vecs[6];

  initial begin
    logic [31:0]  stream;
    logic [W-1:0] w;
    logic [W-1:0] mask;
    int unsigned  n;
    exp_t         e;

    vecs[0] = '{16'hA5C3, 16, 2, 16'hA5C3, 4'd0};
    vecs[1] = '{16'hB800,  5, 2, 16'hB800, 4'd5};
    vecs[2] = '{16'hFFFF,  1, 1, 16'h8000, 4'd1};
    vecs[3] = '{16'h1234, 15, 2, 16'h1234, 4'd15};
    vecs[4] = '{16'hFFFF, 15, 3, 16'hFFFE, 4'd15};
    vecs[5] = '{16'h8001, 16, 0, 16'h8001, 4'd0};

    bus1.ser_data = 1'b0; bus1.ser_data_val = 1'b0;
    bus3.ser_data = 1'b0; bus3.ser_data_val = 1'b0;

    // Reset state
    srst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset data",     32'(bus1.data),     0);
    check("reset mod",      32'(bus1.data_mod), 0);
    check("reset data_val", 32'(bus1.data_val), 0);
    check("reset busy",     32'(bus1.busy),     0);
    check("reset data g3",  32'(bus3.data),     0);
    check("reset busy g3",  32'(bus3.busy),     0);
    srst = 1'b0;
    idle(1, 2);

    // Table-driven single packets
    for (int i = 0; i < 6; i++)
      send(1, vecs[i].word, vecs[i].nbits, vecs[i].gap, 1, vecs[i].exp_data, vecs[i].exp_mod);
    idle(1, 3);

    // Two back-to-back full words; busy drops only on emit cycles
    stream = 32'h1234FFFF;
    for (int i = 0; i < 32; i++) begin
      drive(1, 1'b1, stream[31-i]);
      if ((i + 1) % 16 == 0) begin
        e.data = (i < 16) ? 16'h1234 : 16'hFFFF;
        e.mod  = '0;
        e.cyc  = cyc;
        q1.push_back(e);
      end
      check("stream busy",     32'(bus1.busy),     32'((i + 1) % 16 != 0));
      check("stream data_val", 32'(bus1.data_val), 32'((i + 1) % 16 == 0));
    end
    idle(1, 3);

    // GAP_CYCLES=3: a 2-cycle gap merges, a 3-cycle gap flushes
    drive(3, 1'b1, 1'b1); drive(3, 1'b1, 1'b0); drive(3, 1'b1, 1'b1); drive(3, 1'b1, 1'b0);
    idle(3, 2);
    check("merge busy during short gap", 32'(bus3.busy), 1);
    send(3, 16'hC000, 4, 3, 3, 16'hAC00, 4'd8);
    check("merge busy after flush", 32'(bus3.busy), 0);
    idle(3, 2);

    // Reset mid-word discards it; next word is clean
    for (int i = 0; i < 7; i++) drive(1, 1'b1, 1'b1);
    bus1.ser_data_val = 1'b0;
    srst = 1'b1;
    @(posedge clk);
    #1;
    srst = 1'b0;
    check("midword reset busy",     32'(bus1.busy),     0);
    check("midword reset data_val", 32'(bus1.data_val), 0);
    check("midword reset data",     32'(bus1.data),     0);
    idle(1, 3);
    send(1, 16'h5A5A, 16, 2, 1, 16'h5A5A, 4'd0);

    // Random packets as a serializer would send them (mod 0 = full word)
    for (int p = 0; p < 24; p++) begin
      n    = $urandom_range(1, W);
      w    = W'($urandom);
      mask = 16'hFFFF << (W - n);
      send(1, w, n, (n == W) ? $urandom_range(0, 2) : $urandom_range(1, 3), 1,
           w & mask, (n == W) ? 4'd0 : 4'(n));
    end

    for (int k = 0; k < 40 && (q1.size() != 0 || q3.size() != 0); k++) idle(1, 1);
    check("all words g1 received", q1.size(), 0);
    check("all words g3 received", q3.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
